led_peripheral_multi: RTL and testbench
=======================================

// Module: led_peripheral_multi
// PURPOSE
//  Parametrised memory-mapped LED controller; next generation of the 16-LED register peripheral.
//  Drives NUM_LEDS outputs from byte-wide data registers, with per-block blink, PWM dimming and inversion modes.
//  Adds register read-back. Sits on the same 8-bit address/data write bus as the existing peripherals.
// PARAMETERS
//  NUM_LEDS    16     LED count; multiple of DATA_W; NBYTES = NUM_LEDS/DATA_W
//  ADDR_W      8      address bus width
//  DATA_W      8      data bus width; register width
//  BASE_ADDR   8'h01  address of CTRL; other registers follow contiguously
//  PRESCALE_W  16     prescaler width; tick = prescaler at all-ones
// PORTS
//  clk    in   1           clock, rising edge
//  rst    in   1           asynchronous active-low reset
//  addr   in   ADDR_W      register address
//  wdata  in   DATA_W      write data
//  wr_en  in   1           write strobe, sampled each clk
//  rd_en  in   1           read strobe, sampled each clk
//  rdata  out  DATA_W      read data, registered
//  rvalid out  1           high for 1 cycle when rdata valid
//  led    out  NUM_LEDS    LED drive, registered
// BEHAVIOUR
//  Register map (offset from BASE_ADDR):
//  - +0 CTRL [0]EN [1]BLINK [2]PWM [3]INV; bits[7:4] read 0.
//  - +1..+NBYTES DATA; +1 is the MS byte (led[NUM_LEDS-1 -: 8]), +NBYTES is the LS byte.
//  - +NBYTES+1 DUTY (PWM on-count).
//  - +NBYTES+2 BLINK_DIV (ticks per half-period minus 1).
//  - All other addresses: writes ignored, reads return 0 (with rvalid=1).
//  Reset (rst=0, async): all registers 0; prescaler, PWM and blink counters 0; blink phase 1; led=0; rdata=0; rvalid=0.
//  Write: register updated at the clk edge where wr_en=1; there is no input staging.
//  - led reflects the new value at the following edge (1-cycle led latency).
//  Read: rd_en=1 at edge N -> rdata/rvalid at edge N; rvalid drops at N+1 unless rd_en stays high.
//  - rdata holds its last value while rvalid=0.
//  Same-cycle wr_en and rd_en to the same address: read returns the OLD value.
//  Prescaler: free-running PRESCALE_W counter. tick=1 when it is all-ones; it wraps to 0.
//  Blink: bcnt counts ticks.
//  - On a tick with bcnt==BLINK_DIV: bcnt<=0 and phase toggles; else on a tick: bcnt+1.
//  - BLINK_DIV=0 toggles phase every tick.
//  PWM: free-running 8-bit pcnt, increments every clk and wraps 255->0; pwm_on = (pcnt < DUTY).
//  - DUTY=0 is always off; DUTY=255 is on 255 of 256 cycles.
//  Any CTRL write clears the prescaler, bcnt and pcnt and sets phase=1, so pattern timing is deterministic.
//  LED equation, registered each clk:
//  - raw = EN & (!BLINK | phase) & (!PWM | pwm_on) ? DATA_concat : 0
//  - led <= raw ^ {NUM_LEDS{INV}}
//  - EN=0 with INV=1 gives all-ones.
//  Changing DATA or DUTY does not disturb any counter.
//  Reset asserted mid-operation forces everything to its reset values immediately.
//  Operation resumes from reset values at the first clk edge after rst deasserts.
// TESTING
//  T1 reset: rst=0 during activity -> led=0, rdata=0, rvalid=0 asynchronously; readback of every register is 0.
//  T2 static: write +1=8'hCC, +2=8'hAA, CTRL=8'h01 -> led=16'hCCAA one cycle after the CTRL write.
//  - Then CTRL=8'h00 -> led=16'h0000.
//  T3 invert/readback: CTRL=8'h09, DATA=16'hCCAA -> led=16'h3355.
//  - Read +0 -> rdata=8'h09, rvalid pulses one cycle; read unmapped 8'hF0 -> rdata=0, rvalid=1.
//  T4 blink (PRESCALE_W=4, BLINK_DIV=1): CTRL=8'h03, DATA=16'hFFFF -> led alternates.
//  - Pattern: 16'hFFFF for 32 clks, then 16'h0000 for 32 clks, repeating; first toggle 32 clks after the CTRL write.
//  T5 PWM: DUTY=8'h40, CTRL=8'h05, DATA=16'h0001 -> led[0] high exactly 64 of every 256 cycles.
//  - DUTY=0 -> never high.
//  T6 collision/unmapped: wr_en+rd_en to +1 in one cycle -> rdata=old value, register=new value.
//  - Write to +NBYTES+3 -> no register changes.

Source files
------------

// File: rtl/led_peripheral_multi.sv
// Memory-mapped LED controller: byte-wide DATA registers driving NUM_LEDS outputs,
// with blink, PWM dimming, inversion and registered read-back on an 8-bit write bus.
module led_peripheral_multi #(
  parameter int unsigned       NUM_LEDS   = 16,
  parameter int unsigned       ADDR_W     = 8,
  parameter int unsigned       DATA_W     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 8'h01,
  parameter int unsigned       PRESCALE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                wr_en,
  input  logic                rd_en,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic [NUM_LEDS-1:0] led
);

  localparam int unsigned NBYTES   = NUM_LEDS / DATA_W;
  localparam int unsigned OFF_DUTY = NBYTES + 1;
  localparam int unsigned OFF_BDIV = NBYTES + 2;

  logic [3:0]            r_ctrl;
  logic [NUM_LEDS-1:0]   r_data;
  logic [DATA_W-1:0]     r_duty;
  logic [DATA_W-1:0]     r_bdiv;
  logic [PRESCALE_W-1:0] r_pre;
  logic [DATA_W-1:0]     r_bcnt;
  logic [DATA_W-1:0]     r_pcnt;
  logic                  r_phase;
  logic [NUM_LEDS-1:0]   r_led;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_rvalid;

  logic [ADDR_W-1:0]     w_off;
  logic                  w_inrange;
  logic                  w_ctrl_wr;
  logic                  w_tick;
  logic                  w_pwm_on;
  logic                  w_show;
  logic [DATA_W-1:0]     w_rd_val;

  assign w_off     = addr - BASE_ADDR;
  assign w_inrange = (addr >= BASE_ADDR) && (w_off <= ADDR_W'(OFF_BDIV));
  assign w_ctrl_wr = wr_en && w_inrange && (w_off == '0);
  assign w_tick    = &r_pre;
  assign w_pwm_on  = r_pcnt < r_duty;
  assign w_show    = r_ctrl[0] && (!r_ctrl[1] || r_phase) && (!r_ctrl[2] || w_pwm_on);

  // DATA offset +1 holds the most significant LED byte.
  always_comb begin
    w_rd_val = '0;
    if (w_inrange) begin
      if (w_off == '0)
        w_rd_val = DATA_W'(r_ctrl);
      else if (w_off == ADDR_W'(OFF_DUTY))
        w_rd_val = r_duty;
      else if (w_off == ADDR_W'(OFF_BDIV))
        w_rd_val = r_bdiv;
      else
        for (int unsigned i = 0; i < NBYTES; i++)
          if (w_off == ADDR_W'(i + 1))
            w_rd_val = r_data[(NBYTES-1-i)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl <= '0;
      r_data <= '0;
      r_duty <= '0;
      r_bdiv <= '0;
    end else if (wr_en && w_inrange) begin
      if (w_off == '0)
        r_ctrl <= wdata[3:0];
      else if (w_off == ADDR_W'(OFF_DUTY))
        r_duty <= wdata;
      else if (w_off == ADDR_W'(OFF_BDIV))
        r_bdiv <= wdata;
      else
        for (int unsigned i = 0; i < NBYTES; i++)
          if (w_off == ADDR_W'(i + 1))
            r_data[(NBYTES-1-i)*DATA_W +: DATA_W] <= wdata;
    end
  end

  // A CTRL write restarts all pattern timing from a known phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre   <= '0;
      r_bcnt  <= '0;
      r_pcnt  <= '0;
      r_phase <= 1'b1;
    end else if (w_ctrl_wr) begin
      r_pre   <= '0;
      r_bcnt  <= '0;
      r_pcnt  <= '0;
      r_phase <= 1'b1;
    end else begin
      r_pre  <= r_pre + PRESCALE_W'(1);
      r_pcnt <= r_pcnt + DATA_W'(1);
      if (w_tick) begin
        if (r_bcnt == r_bdiv) begin
          r_bcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_bcnt <= r_bcnt + DATA_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_led    <= (w_show ? r_data : '0) ^ {NUM_LEDS{r_ctrl[3]}};
      r_rvalid <= rd_en;
      if (rd_en)
        r_rdata <= w_rd_val;
    end
  end

  assign led    = r_led;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;

endmodule

// File: tb/tb_led_peripheral_multi.sv
// Self-checking bench for led_peripheral_multi: directed scenarios plus randomized
// traffic checked against a time-since-restart reference model.
module tb_led_peripheral_multi;

  localparam logic [7:0] BASE   = 8'h01;
  localparam logic [7:0] DATA_A = 8'h02;
  localparam logic [7:0] DATA_B = 8'h03;
  localparam logic [7:0] DUTY_A = 8'h04;
  localparam logic [7:0] BDIV_A = 8'h05;
  localparam logic [7:0] UNMAP  = 8'h06;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [15:0] led;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: register file plus cycles elapsed since the last timing restart.
  logic [7:0]  m_reg [0:4];
  int          m_t;
  int          m_bsnap;
  logic [15:0] m_led;
  logic [7:0]  m_rdata;
  logic        m_rvalid;

  led_peripheral_multi #(
    .NUM_LEDS(16), .ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'h01), .PRESCALE_W(4)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wr_en(wr_en), .rd_en(rd_en),
    .rdata(rdata), .rvalid(rvalid), .led(led)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_read(input logic [7:0] a);
    int off;
    off = int'(a) - int'(BASE);
    if (off >= 0 && off <= 4) return m_reg[off];
    return 8'h00;
  endfunction

  // Prescaler of 16 clocks: ticks = t/16; phase flips every (BLINK_DIV+1) ticks; pcnt = t mod 256.
  function automatic logic [15:0] m_led_now();
    logic [15:0] d;
    int          ticks;
    bit          phase;
    bit          pwm_on;
    bit          show;
    d      = {m_reg[1], m_reg[2]};
    ticks  = m_t / 16;
    phase  = ((ticks / (m_bsnap + 1)) % 2) == 0;
    pwm_on = (m_t % 256) < int'(m_reg[3]);
    show   = m_reg[0][0] && (!m_reg[0][1] || phase) && (!m_reg[0][2] || pwm_on);
    return (show ? d : 16'h0000) ^ (m_reg[0][3] ? 16'hFFFF : 16'h0000);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
    m_t      = 0;
    m_bsnap  = 0;
    m_led    = 16'h0000;
    m_rdata  = 8'h00;
    m_rvalid = 1'b0;
  endtask

  // Apply one bus cycle: inputs are presented now, the model advances, then wait past the edge.
  task automatic cyc(input logic [7:0] a, input logic [7:0] d, input logic we, input logic re);
    int off;
    addr  = a;
    wdata = d;
    wr_en = we;
    rd_en = re;
    m_led    = m_led_now();
    m_rvalid = re;
    if (re) m_rdata = m_read(a);
    off = int'(a) - int'(BASE);
    if (we && off >= 0 && off <= 4) m_reg[off] = (off == 0) ? (d & 8'h0F) : d;
    if (we && off == 0) begin
      m_t     = 0;
      m_bsnap = int'(m_reg[4]);
    end else begin
      m_t++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cyc(DATA_A, 8'h12, 1'b1, 1'b0);
    cyc(BASE, 8'h09, 1'b1, 1'b0);
    idle();
    cyc(BASE, 8'h00, 1'b0, 1'b1);
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 8'h09) begin
      n_fail++;
      $display("FAIL reset_pre rvalid/rdata got %b/%h want 1/09", rvalid, rdata);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (led !== 16'h0000 || rdata !== 8'h00 || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async led/rdata/rvalid got %h/%h/%b want 0000/00/0", led, rdata, rvalid);
    end
    model_reset();
    addr = 8'h00; wdata = 8'h00; wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(8'(BASE + i), 8'h00, 1'b0, 1'b1);
      n_cmp++;
      if (rdata !== 8'h00 || rvalid !== 1'b1 || led !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_readback off %0d rdata/rvalid/led got %h/%b/%h want 00/1/0000", i, rdata, rvalid, led);
      end
    end
  endtask

  task automatic test_static();
    cyc(DATA_A, 8'hCC, 1'b1, 1'b0);
    cyc(DATA_B, 8'hAA, 1'b1, 1'b0);
    cyc(BASE, 8'h01, 1'b1, 1'b0);
    n_cmp++;
    if (led !== 16'h0000) begin
      n_fail++;
      $display("FAIL static_latency led got %h want 0000", led);
    end
    idle();
    n_cmp++;
    if (led !== 16'hCCAA) begin
      n_fail++;
      $display("FAIL static_on led got %h want ccaa", led);
    end
    cyc(BASE, 8'h00, 1'b1, 1'b0);
    idle();
    n_cmp++;
    if (led !== 16'h0000) begin
      n_fail++;
      $display("FAIL static_off led got %h want 0000", led);
    end
  endtask

  task automatic test_invert_readback();
    cyc(BASE, 8'h09, 1'b1, 1'b0);
    idle();
    n_cmp++;
    if (led !== 16'h3355) begin
      n_fail++;
      $display("FAIL inv_led led got %h want 3355", led);
    end
    cyc(BASE, 8'h00, 1'b0, 1'b1);
    n_cmp++;
    if (rdata !== 8'h09 || rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_ctrl rdata/rvalid got %h/%b want 09/1", rdata, rvalid);
    end
    idle();
    n_cmp++;
    if (rdata !== 8'h09 || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_hold rdata/rvalid got %h/%b want 09/0", rdata, rvalid);
    end
    cyc(8'hF0, 8'h00, 1'b0, 1'b1);
    n_cmp++;
    if (rdata !== 8'h00 || rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_unmapped rdata/rvalid got %h/%b want 00/1", rdata, rvalid);
    end
  endtask

  task automatic test_blink();
    int errs;
    logic [15:0] exp;
    cyc(DATA_A, 8'hFF, 1'b1, 1'b0);
    cyc(DATA_B, 8'hFF, 1'b1, 1'b0);
    cyc(BDIV_A, 8'h01, 1'b1, 1'b0);
    cyc(BASE, 8'h03, 1'b1, 1'b0);
    errs = 0;
    for (int k = 1; k <= 128; k++) begin
      idle();
      exp = (((k - 1) / 32) % 2 == 0) ? 16'hFFFF : 16'h0000;
      if (led !== exp) begin
        if (errs == 0) $display("FAIL blink cycle %0d led got %h want %h", k, led, exp);
        errs++;
      end
    end
    n_cmp++;
    if (errs != 0) n_fail++;
  endtask

  task automatic test_pwm();
    int ons;
    cyc(DATA_A, 8'h00, 1'b1, 1'b0);
    cyc(DATA_B, 8'h01, 1'b1, 1'b0);
    cyc(DUTY_A, 8'h40, 1'b1, 1'b0);
    cyc(BASE, 8'h05, 1'b1, 1'b0);
    ons = 0;
    for (int k = 1; k <= 256; k++) begin
      idle();
      if (led[0] === 1'b1) ons++;
    end
    n_cmp++;
    if (ons != 64) begin
      n_fail++;
      $display("FAIL pwm_64 on-cycles got %0d want 64", ons);
    end
    cyc(DUTY_A, 8'h00, 1'b1, 1'b0);
    ons = 0;
    for (int k = 1; k <= 256; k++) begin
      idle();
      if (led !== 16'h0000) ons++;
    end
    n_cmp++;
    if (ons != 0) begin
      n_fail++;
      $display("FAIL pwm_zero on-cycles got %0d want 0", ons);
    end
  endtask

  task automatic test_collision();
    cyc(DATA_A, 8'h5A, 1'b1, 1'b0);
    cyc(DATA_A, 8'hA7, 1'b1, 1'b1);
    n_cmp++;
    if (rdata !== 8'h5A || rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_old rdata/rvalid got %h/%b want 5a/1", rdata, rvalid);
    end
    cyc(DATA_A, 8'h00, 1'b0, 1'b1);
    n_cmp++;
    if (rdata !== 8'hA7) begin
      n_fail++;
      $display("FAIL collide_new rdata got %h want a7", rdata);
    end
    cyc(UNMAP, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i <= 5; i++) begin
      cyc(8'(BASE + i), 8'h00, 1'b0, 1'b1);
      n_cmp++;
      if (rdata !== m_read(8'(BASE + i)) || rvalid !== 1'b1) begin
        n_fail++;
        $display("FAIL unmapped_wr off %0d rdata got %h want %h", i, rdata, m_read(8'(BASE + i)));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, d;
    logic       we, re;
    bit         follow;
    int         errs;
    errs = 0;
    for (int i = 0; i < 1500; i++) begin
      a  = ($urandom_range(0, 15) == 0) ? 8'hF0 : 8'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      d  = (a == BDIV_A) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      follow = we && (a == BDIV_A);
      for (int j = 0; j < 2; j++) begin
        if (j == 1) begin
          if (!follow) break;
          a  = BASE;
          d  = 8'($urandom_range(0, 15));
          we = 1'b1;
          re = 1'($urandom_range(0, 1));
        end
        cyc(a, d, we, re);
        n_cmp++;
        if (led !== m_led || rvalid !== m_rvalid || rdata !== m_rdata) begin
          n_fail++;
          if (errs < 5)
            $display("FAIL random cyc %0d led/rvalid/rdata got %h/%b/%h want %h/%b/%h",
                     i, led, rvalid, rdata, m_led, m_rvalid, m_rdata);
          errs++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    addr = 8'h00; wdata = 8'h00; wr_en = 1'b0; rd_en = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_static();
    test_invert_readback();
    test_blink();
    test_pwm();
    test_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
